// File: rtl/nocr_pack_gen_if.sv
// Signal bundle between the host, the packet generator and the NoC-router controller.
// The slave modport is the generator's view; the master modport drives it.
interface nocr_pack_gen_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_dest;
   logic [1:0]        req_type;
   logic [DATA_W-1:0] req_data;
   logic              pack_valid;
   logic              nocr_ready;
   logic [DATA_W+3:0] packet;
   logic              nocr_valid;
   logic              pack_gen_ready;
   logic [DATA_W-1:0] nocr_data;
   logic              nocr_err;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              rsp_timeout;
   logic [7:0]        drop_cnt;

   modport slave (
      input  req_valid, req_dest, req_type, req_data,
      input  nocr_ready, nocr_valid, nocr_data, nocr_err, rsp_ready,
      output req_ready, pack_valid, packet, pack_gen_ready,
      output rsp_valid, rsp_data, rsp_err, rsp_timeout, drop_cnt
   );

   modport master (
      output req_valid, req_dest, req_type, req_data,
      output nocr_ready, nocr_valid, nocr_data, nocr_err, rsp_ready,
      input  req_ready, pack_valid, packet, pack_gen_ready,
      input  rsp_valid, rsp_data, rsp_err, rsp_timeout, drop_cnt
   );
endinterface

// File: rtl/nocr_pack_gen.sv
// Packet generator: queues host requests, sends one packet at a time to the router,
// waits for its response or a timeout, and hands the result back to the host.
module nocr_pack_gen #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input logic            clk,
   input logic            reset,
   nocr_pack_gen_if.slave bus
);
   localparam int PW = DATA_W + 4;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RESP,
      DELIVER
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     mem_q [DEPTH];
   logic [AW-1:0]     wrPtr_q, rdPtr_q;
   logic [CW-1:0]     count_q;
   logic [TW-1:0]     timer_q;
   logic [DATA_W-1:0] rspData_q;
   logic              rspErr_q;
   logic              rspTimeout_q;
   logic [7:0]        dropCnt_q;

   logic full, empty, push, pop, respHit, timeoutHit, drop;

   // A response arriving on the same cycle as the timeout takes priority.
   assign full       = (count_q == FULL_CNT);
   assign empty      = (count_q == '0);
   assign push       = bus.req_valid && !full;
   assign pop        = (state_q == SEND) && bus.nocr_ready;
   assign respHit    = (state_q == WAIT_RESP) && bus.nocr_valid;
   assign timeoutHit = (state_q == WAIT_RESP) && !bus.nocr_valid && (timer_q == TIMER_LAST);
   assign drop       = bus.nocr_valid && (state_q == IDLE || state_q == SEND);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (!empty) state_d = SEND;
         SEND:      if (bus.nocr_ready) state_d = WAIT_RESP;
         WAIT_RESP: if (respHit || timeoutHit) state_d = DELIVER;
         DELIVER:   if (bus.rsp_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Request FIFO; the head stays put while SEND waits for the router.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_q[wrPtr_q] <= {bus.req_type, bus.req_dest, bus.req_data};
            wrPtr_q        <= wrPtr_q + AW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q      <= '0;
         rspData_q    <= '0;
         rspErr_q     <= 1'b0;
         rspTimeout_q <= 1'b0;
         dropCnt_q    <= '0;
      end else begin
         if (pop) begin
            timer_q <= '0;
         end else if (state_q == WAIT_RESP) begin
            timer_q <= timer_q + TW'(1);
         end
         if (respHit) begin
            rspData_q    <= bus.nocr_data;
            rspErr_q     <= bus.nocr_err;
            rspTimeout_q <= 1'b0;
         end else if (timeoutHit) begin
            rspData_q    <= '0;
            rspErr_q     <= 1'b0;
            rspTimeout_q <= 1'b1;
         end
         // Late responses are swallowed here; the counter sticks at its maximum.
         if (drop && dropCnt_q != 8'hFF) begin
            dropCnt_q <= dropCnt_q + 8'd1;
         end
      end
   end

   assign bus.req_ready      = !full;
   assign bus.pack_valid     = (state_q == SEND);
   assign bus.packet         = (state_q == SEND) ? mem_q[rdPtr_q] : '0;
   assign bus.pack_gen_ready = (state_q != DELIVER);
   assign bus.rsp_valid      = (state_q == DELIVER);
   assign bus.rsp_data       = rspData_q;
   assign bus.rsp_err        = rspErr_q;
   assign bus.rsp_timeout    = rspTimeout_q;
   assign bus.drop_cnt       = dropCnt_q;
endmodule

// File: tb/tb_nocr_pack_gen.sv
// Randomised scoreboard bench for nocr_pack_gen: host and router models feed expected
// packets/responses into queues that a negedge monitor consumes.
`timescale 1ns/1ps
module tb_nocr_pack_gen;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int NUM_REQ = 60;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
      logic              timeout;
   } rsp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   nocr_pack_gen_if #(.DATA_W(DATA_W)) bus ();

   nocr_pack_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DATA_W+3:0] pktQ [$];
   rsp_t              rspQ [$];
   int checkCount = 0;
   int passCount  = 0;
   int fifoOcc    = 0;
   int expDrop    = 0;
   int delivered  = 0;
   bit stopRouter = 1'b0;
   bit routerDone = 1'b0;
   bit forceRspReady = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reportFail(input string name);
      checkCount++;
      $display("[TB] FAIL %s at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Host request: hold valid until accepted, then record the packet it must become.
   task automatic applyStimulus(input logic [1:0] dest, input logic [1:0] typ,
                                input logic [DATA_W-1:0] data);
      int waitCnt = 0;
      bit accepted = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_dest  = dest;
      bus.req_type  = typ;
      bus.req_data  = data;
      while (waitCnt < 2000) begin
         @(negedge clk);
         if (bus.req_ready) begin
            accepted = 1'b1;
            break;
         end
         waitCnt++;
      end
      if (accepted) pktQ.push_back({typ, dest, data});
      else reportFail("req_accept_timeout");
      tick();
      bus.req_valid = 1'b0;
   endtask

   // Monitor: FIFO-level backpressure, stability while stalled, and scoreboard pops.
   logic              prevPackHeld = 1'b0;
   logic [DATA_W+3:0] prevPacket;
   logic              prevRspHeld  = 1'b0;
   rsp_t              prevRsp;
   always @(negedge clk) begin
      if (reset) begin
         prevPackHeld = 1'b0;
         prevRspHeld  = 1'b0;
      end else begin
         rsp_t got;
         got = {bus.rsp_data, bus.rsp_err, bus.rsp_timeout};
         checkOutput("req_ready", bus.req_ready, fifoOcc < DEPTH);
         if (bus.rsp_valid) checkOutput("pack_gen_ready_deliver", bus.pack_gen_ready, 0);
         if (prevPackHeld) begin
            checkOutput("pack_valid_held", bus.pack_valid, 1);
            checkOutput("packet_stable", bus.packet, prevPacket);
         end
         if (prevRspHeld) begin
            checkOutput("rsp_valid_held", bus.rsp_valid, 1);
            checkOutput("rsp_stable", got, prevRsp);
         end
         if (bus.pack_valid && bus.nocr_ready) begin
            if (pktQ.size() == 0) reportFail("packet_unexpected");
            else checkOutput("packet", bus.packet, pktQ.pop_front());
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (rspQ.size() == 0) reportFail("rsp_unexpected");
            else checkOutput("rsp", got, rspQ.pop_front());
            delivered++;
         end
         fifoOcc += int'(bus.req_valid && bus.req_ready) - int'(bus.pack_valid && bus.nocr_ready);
         prevPackHeld = bus.pack_valid && !bus.nocr_ready;
         prevPacket   = bus.packet;
         prevRspHeld  = bus.rsp_valid && !bus.rsp_ready;
         prevRsp      = got;
      end
   end

   initial begin
      bus.rsp_ready = 1'b0;
      forever begin
         tick();
         bus.rsp_ready = forceRspReady ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
   end

   // Router model: one packet at a time, answered in time, or timed out with a late reply.
   initial begin
      bit   accepted;
      int   k;
      int   cnt;
      rsp_t e;
      bus.nocr_ready = 1'b0;
      bus.nocr_valid = 1'b0;
      bus.nocr_data  = '0;
      bus.nocr_err   = 1'b0;
      @(negedge reset);
      while (!stopRouter) begin
         accepted = 1'b0;
         while (!accepted && !stopRouter) begin
            tick();
            bus.nocr_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accepted = bus.pack_valid && bus.nocr_ready;
         end
         if (!accepted) break;
         tick();
         bus.nocr_ready = 1'b0;
         if ($urandom_range(0, 3) != 0) begin
            k = ($urandom_range(0, 2) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, TIMEOUT - 1));
            e.data    = $urandom;
            e.err     = 1'($urandom_range(0, 1));
            e.timeout = 1'b0;
            rspQ.push_back(e);
            repeat (k) tick();
            bus.nocr_valid = 1'b1;
            bus.nocr_data  = e.data;
            bus.nocr_err   = e.err;
            tick();
            bus.nocr_valid = 1'b0;
            @(negedge clk);
            checkOutput("rsp_latency", bus.rsp_valid, 1);
         end else begin
            e = '0;
            e.timeout = 1'b1;
            rspQ.push_back(e);
            cnt = 0;
            while (cnt < TIMEOUT + 20) begin
               @(negedge clk);
               if (bus.rsp_valid) break;
               cnt++;
            end
            checkOutput("timeout_latency", cnt, TIMEOUT);
            if ($urandom_range(0, 1) == 1) begin
               tick();
               bus.nocr_valid = 1'b1;
               bus.nocr_data  = $urandom;
               bus.nocr_err   = 1'($urandom_range(0, 1));
               cnt = 0;
               while (cnt < 200) begin
                  @(negedge clk);
                  if (bus.pack_gen_ready) break;
                  cnt++;
               end
               if (cnt >= 200) reportFail("late_rsp_never_accepted");
               tick();
               bus.nocr_valid = 1'b0;
               expDrop = (expDrop < 255) ? expDrop + 1 : 255;
            end
         end
      end
      bus.nocr_ready = 1'b0;
      bus.nocr_valid = 1'b0;
      routerDone = 1'b1;
   end

   initial begin
      int cnt;
      bus.req_valid = 1'b0;
      bus.req_dest  = '0;
      bus.req_type  = '0;
      bus.req_data  = '0;
      @(negedge clk);
      checkOutput("reset_req_ready", bus.req_ready, 1);
      checkOutput("reset_pack_gen_ready", bus.pack_gen_ready, 1);
      checkOutput("reset_pack_valid", bus.pack_valid, 0);
      checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
      checkOutput("reset_rsp_timeout", bus.rsp_timeout, 0);
      checkOutput("reset_drop_cnt", bus.drop_cnt, 0);
      tick();
      reset = 1'b0;

      applyStimulus(2'd2, 2'd0, 32'h0000_00A5);
      for (int i = 1; i < NUM_REQ; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
         applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
      end

      cnt = 0;
      while (delivered < NUM_REQ && cnt < 20000) begin
         @(negedge clk);
         cnt++;
      end
      if (delivered < NUM_REQ) reportFail("delivery_timeout");
      stopRouter = 1'b1;
      cnt = 0;
      while (!routerDone && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      if (!routerDone) reportFail("router_stop_timeout");
      @(negedge clk);
      checkOutput("drop_cnt", bus.drop_cnt, expDrop);
      checkOutput("queues_drained", pktQ.size() + rspQ.size(), 0);

      // Stray responses while idle saturate the drop counter.
      forceRspReady = 1'b1;
      tick();
      bus.nocr_valid = 1'b1;
      repeat (300) begin
         tick();
         expDrop = (expDrop < 255) ? expDrop + 1 : 255;
      end
      bus.nocr_valid = 1'b0;
      @(negedge clk);
      checkOutput("drop_cnt_saturated", bus.drop_cnt, expDrop);
      checkOutput("pack_gen_ready_idle", bus.pack_gen_ready, 1);

      // Reset while waiting for a response with two requests still queued.
      tick();
      applyStimulus(2'd1, 2'd1, 32'h1111_0001);
      applyStimulus(2'd3, 2'd2, 32'h2222_0002);
      applyStimulus(2'd0, 2'd3, 32'h3333_0003);
      bus.nocr_ready = 1'b1;
      tick();
      bus.nocr_ready = 1'b0;
      @(negedge clk);
      checkOutput("wait_pack_valid", bus.pack_valid, 0);
      checkOutput("wait_req_ready", bus.req_ready, 1);
      reset = 1'b1;
      #1;
      pktQ.delete();
      rspQ.delete();
      fifoOcc = 0;
      checkOutput("midreset_req_ready", bus.req_ready, 1);
      checkOutput("midreset_pack_valid", bus.pack_valid, 0);
      checkOutput("midreset_packet", bus.packet, 0);
      checkOutput("midreset_pack_gen_ready", bus.pack_gen_ready, 1);
      checkOutput("midreset_rsp_valid", bus.rsp_valid, 0);
      checkOutput("midreset_drop_cnt", bus.drop_cnt, 0);
      tick();
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checkOutput("post_reset_fifo_empty", bus.pack_valid, 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
